onehot_line_decoder: RTL and testbench

//  Binary-to-one-hot line decoder; the receive-side counterpart of our priority encoders.
//  - Accepts an encoded line index over a valid/ready handshake.
//  - Drives the matching single output line for a bounded hold window.
//  - Releases the line on downstream ack or on timeout, then enforces an all-low gap.
//  - Sits between the encoder-side request path and the per-line consumers.

---
 rtl/onehot_line_decoder.sv | 124 ++++++++++++
 tb/tb_onehot_line_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_line_decoder.sv
// Binary-to-one-hot line decoder with bounded hold, ack/timeout release and an all-low gap.
// Optional macro DECODE_PARITY_EN adds even-parity checking on in_code (in_parity/err_parity).

// state | meaning
// IDLE  | no line driven; serves the pending slot first, else bypasses a fresh transfer
// DRIVE | one line high; released on out_ack or when the hold counter expires
// GAP   | enforced all-low cycles before returning to IDLE
module onehot_line_decoder #(
  parameter int IDX_W       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  localparam int OUT_W      = 2**IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_code,
  output logic [OUT_W-1:0] out_lines,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             timeout
`ifdef DECODE_PARITY_EN
  ,
  input  logic             in_parity,
  output logic             err_parity
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_full;
  logic [IDX_W-1:0] pend_code;
  logic             xfer;
  logic             code_ok;
  logic             take;

  function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  // Ready depends only on the registered slot, so out_ack never reaches in_ready.
  assign in_ready = ~pend_full;
  assign xfer     = in_valid & in_ready;

`ifdef DECODE_PARITY_EN
  assign code_ok = ((^in_code) == in_parity);
`else
  assign code_ok = 1'b1;
`endif

  assign take = xfer & code_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_full <= 1'b0;
      pend_code <= '0;
      out_lines <= '0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
`ifdef DECODE_PARITY_EN
      err_parity <= 1'b0;
`endif
    end else begin
      timeout <= 1'b0;
`ifdef DECODE_PARITY_EN
      err_parity <= xfer & ~code_ok;
`endif
      case (state)
        IDLE: begin
          // A full slot blocks in_ready, so the slot and the bypass never compete.
          if (pend_full || take) begin
            out_lines <= decode(pend_full ? pend_code : in_code);
            out_valid <= 1'b1;
            pend_full <= 1'b0;
            cnt       <= HOLD_LOAD;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (take) begin
            pend_full <= 1'b1;
            pend_code <= in_code;
          end
          if (out_ack || cnt == '0) begin
            timeout   <= ~out_ack;
            out_lines <= '0;
            out_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (take) begin
            pend_full <= 1'b1;
            pend_code <= in_code;
          end
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_line_decoder.sv
// Scoreboard bench for onehot_line_decoder (IDX_W=2, HOLD_CYCLES=4, GAP_CYCLES=1).
// Define DECODE_PARITY_EN to also exercise the parity-drop path.
module tb_onehot_line_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic [3:0] out_lines;
  logic       out_valid;
  logic       out_ack;
  logic       timeout;
`ifdef DECODE_PARITY_EN
  logic       in_parity;
  logic       err_parity;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  onehot_line_decoder #(
    .IDX_W(2),
    .HOLD_CYCLES(4),
    .GAP_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_code(in_code),
    .out_lines(out_lines),
    .out_valid(out_valid),
    .out_ack(out_ack),
    .timeout(timeout)
`ifdef DECODE_PARITY_EN
    ,
    .in_parity(in_parity),
    .err_parity(err_parity)
`endif
  );

  function automatic logic [3:0] line_of(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a code until it is accepted; the expected line is queued at the accept edge.
  task automatic send(input logic [1:0] code, output bit ok);
    in_code  = code;
    in_valid = 1'b1;
`ifdef DECODE_PARITY_EN
    in_parity = ^code;
`endif
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(line_of(code));
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Called in a cycle where a line is high; returns once it is released (or the bound expires).
  task automatic run_drive(input int ack_at, output int hold, output int to_during,
                           output int to_release, output logic [3:0] lines_or);
    hold      = 1;
    to_during = 0;
    lines_or  = out_lines;
    out_ack   = (ack_at == 1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (!out_valid) break;
      hold++;
      lines_or  |= out_lines;
      to_during += int'(timeout);
      out_ack    = (ack_at == hold);
    end
    out_ack    = 1'b0;
    to_release = int'(timeout);
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!out_valid && waited < 50) begin
      step();
      waited++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ack = 1'b0;
`ifdef DECODE_PARITY_EN
    in_parity = 1'b0;
`endif
    step(); step();
    vectors++; if (out_lines !== 4'b0000) begin miscompares++; $display("FAIL rst_lines: got %b want 0000", out_lines); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_timeout();
    bit ok; int hold, tdur, trel; logic [3:0] lor, want;
    send(2'b10, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t1_accept: got not accepted want accepted"); end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (out_lines !== want || out_valid !== 1'b1) begin miscompares++; $display("FAIL t1_line: got %b/%b want %b/1", out_lines, out_valid, want); end
    run_drive(0, hold, tdur, trel, lor);
    vectors++; if (hold != 4) begin miscompares++; $display("FAIL t1_hold: got %0d want 4", hold); end
    vectors++; if (trel != 1 || tdur != 0) begin miscompares++; $display("FAIL t1_timeout: got rel=%0d during=%0d want rel=1 during=0", trel, tdur); end
    vectors++; if (lor !== 4'b0100) begin miscompares++; $display("FAIL t1_lines_or: got %b want 0100", lor); end
    step();
    vectors++; if (timeout !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL t1_after: got to=%b valid=%b want 0/0", timeout, out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL t1_idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ack_early();
    bit ok; int hold, tdur, trel; logic [3:0] lor, want;
    send(2'b01, ok);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (!ok || out_lines !== want) begin miscompares++; $display("FAIL t2_line: got %b want %b", out_lines, want); end
    run_drive(2, hold, tdur, trel, lor);
    vectors++; if (hold != 2) begin miscompares++; $display("FAIL t2_hold: got %0d want 2", hold); end
    vectors++; if (tdur + trel != 0) begin miscompares++; $display("FAIL t2_timeout: got %0d pulses want 0", tdur + trel); end
    vectors++; if (lor !== 4'b0010) begin miscompares++; $display("FAIL t2_lines_or: got %b want 0010", lor); end
    step(); step();
  endtask

  task automatic test_ack_last();
    bit ok; int hold, tdur, trel; logic [3:0] lor, want;
    send(2'b00, ok);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (!ok || out_lines !== want) begin miscompares++; $display("FAIL t3_line: got %b want %b", out_lines, want); end
    run_drive(4, hold, tdur, trel, lor);
    vectors++; if (hold != 4) begin miscompares++; $display("FAIL t3_hold: got %0d want 4", hold); end
    vectors++; if (tdur + trel != 0) begin miscompares++; $display("FAIL t3_timeout: got %0d pulses want 0", tdur + trel); end
    step();
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL t3_after: got %b want 0", timeout); end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok; int hold, tdur, trel, waited; logic [3:0] lor, want;
    send(2'b11, ok);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (!ok || out_lines !== want) begin miscompares++; $display("FAIL t4_line3: got %b want %b", out_lines, want); end
    in_code = 2'b00; in_valid = 1'b1;
`ifdef DECODE_PARITY_EN
    in_parity = 1'b0;
`endif
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL t4_ready_drive: got %b want 1", in_ready); end
    exp_q.push_back(line_of(2'b00));
    step();
    in_code = 2'b01;
`ifdef DECODE_PARITY_EN
    in_parity = 1'b1;
`endif
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL t4_ready_full: got %b want 0", in_ready); end
    run_drive(0, hold, tdur, trel, lor);
    vectors++; if (trel != 1 || lor !== 4'b1000) begin miscompares++; $display("FAIL t4_first_end: got to=%0d lines=%b want 1/1000", trel, lor); end
    wait_valid(waited);
    vectors++; if (waited != 2) begin miscompares++; $display("FAIL t4_gap: got %0d low cycles want 2", waited); end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (out_lines !== want) begin miscompares++; $display("FAIL t4_line0: got %b want %b", out_lines, want); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL t4_ready_popped: got %b want 1", in_ready); end
    exp_q.push_back(line_of(2'b01));
    step();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL t4_ready_refill: got %b want 0", in_ready); end
    run_drive(0, hold, tdur, trel, lor);
    wait_valid(waited);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (out_lines !== want) begin miscompares++; $display("FAIL t4_line1: got %b want %b", out_lines, want); end
    run_drive(1, hold, tdur, trel, lor);
    vectors++; if (hold != 1 || trel != 0) begin miscompares++; $display("FAIL t4_ack_first: got hold=%0d to=%0d want 1/0", hold, trel); end
    step(); step();
  endtask

  task automatic test_reset_mid_drive();
    bit ok; int seen; logic [3:0] want;
    send(2'b10, ok);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (!ok || out_lines !== want) begin miscompares++; $display("FAIL t5_line: got %b want %b", out_lines, want); end
    in_code = 2'b11; in_valid = 1'b1;
`ifdef DECODE_PARITY_EN
    in_parity = 1'b0;
`endif
    step();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL t5_pending: got ready=%b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_lines !== 4'b0000 || out_valid !== 1'b0) begin miscompares++; $display("FAIL t5_async_out: got %b/%b want 0000/0", out_lines, out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL t5_async_ready: got %b want 1", in_ready); end
    step();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen += int'(out_valid);
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL t5_pending_dropped: got %0d drive cycles want 0", seen); end
  endtask

`ifdef DECODE_PARITY_EN
  task automatic test_parity();
    bit ok; int hold, tdur, trel; logic [3:0] lor, want;
    in_code = 2'b11; in_parity = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (err_parity !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL t6_err: got err=%b valid=%b want 1/0", err_parity, out_valid); end
    step();
    vectors++; if (err_parity !== 1'b0 || out_lines !== 4'b0000) begin miscompares++; $display("FAIL t6_err_clear: got err=%b lines=%b want 0/0000", err_parity, out_lines); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL t6_no_pending: got ready=%b want 1", in_ready); end
    send(2'b10, ok);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    vectors++; if (!ok || out_lines !== want || err_parity !== 1'b0) begin miscompares++; $display("FAIL t6_good: got %b err=%b want %b err=0", out_lines, err_parity, want); end
    run_drive(1, hold, tdur, trel, lor);
    step(); step();
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_ack_early();
    test_ack_last();
    test_back_to_back();
    test_reset_mid_drive();
`ifdef DECODE_PARITY_EN
    test_parity();
`endif
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
